// File: rtl/mv_pkg.sv
// Shared constants and FSM state type for the motion-vector result packer.
package mv_pkg;

    localparam int SAE_W_DEF = 10;
    localparam int MV_W_DEF  = 3;
    localparam int REC_W     = 16;
    localparam int BYTE_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_HI = 2'd1,
        ST_SEND_LO = 2'd2
    } mv_state_e;

endpackage

// File: rtl/mv_result_fifo.sv
// Synchronous record FIFO with head-peek; a push into a full FIFO is taken only
// when a pop happens on the same edge.
module mv_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mv_result_packer.sv
// Queues 16-bit search results {min_sae, mv_y, mv_x} and streams each one out
// as two bytes, high byte first, over a valid/ready byte interface.
module mv_result_packer
    import mv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SAE_W = SAE_W_DEF,
    parameter int MV_W  = MV_W_DEF
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   res_valid,
    input  logic [SAE_W-1:0]       min_sae,
    input  logic [MV_W-1:0]        motion_vec_x,
    input  logic [MV_W-1:0]        motion_vec_y,
    input  logic                   out_ready,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output mv_state_e              dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Byte handshake: a byte transfers on a rising edge where out_valid && out_ready.
    // out_valid/out_data/out_last depend only on registered state, never on out_ready.

    mv_state_e        state_q, state_d;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    assign rec_in  = {min_sae, motion_vec_y, motion_vec_x};
    assign pop     = (state_q == ST_SEND_LO) && out_ready;
    assign push_ok = res_valid && (!fifo_full || pop);
    assign drop    = res_valid && fifo_full && !pop;

    mv_result_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (res_valid),
        .data_i  (rec_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // A same-edge push counts as a remaining record, so streaming has no idle gap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_SEND_HI;
            ST_SEND_HI: if (out_ready) state_d = ST_SEND_LO;
            ST_SEND_LO: begin
                if (out_ready) begin
                    if ((fifo_count > CNT_W'(1)) || push_ok) state_d = ST_SEND_HI;
                    else                                     state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        unique case (state_q)
            ST_SEND_HI: begin
                out_valid = 1'b1;
                out_data  = head[REC_W-1:BYTE_W];
            end
            ST_SEND_LO: begin
                out_valid = 1'b1;
                out_data  = head[BYTE_W-1:0];
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mv_result_packer.sv
// Directed bench for mv_result_packer: latency, back-pressure, overflow,
// full-with-pop, streaming across pointer wrap, and reset mid-record.
module tb_mv_result_packer;
  import mv_pkg::*;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       res_valid;
  logic [9:0] min_sae;
  logic [2:0] motion_vec_x;
  logic [2:0] motion_vec_y;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [7:0] drop_cnt;
  mv_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  mv_result_packer #(.DEPTH(4), .SAE_W(10), .MV_W(3)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .res_valid    (res_valid),
    .min_sae      (min_sae),
    .motion_vec_x (motion_vec_x),
    .motion_vec_y (motion_vec_y),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst_i  = 1'b1;
    res_valid = 1'b0;
    tick();
    tick();
    wb_rst_i  = 1'b0;
  endtask

  // driver: record layout is {min_sae[9:0], mv_y[2:0], mv_x[2:0]}
  task automatic drive_rec(input logic [15:0] rec);
    res_valid    = 1'b1;
    min_sae      = rec[15:6];
    motion_vec_y = rec[5:3];
    motion_vec_x = rec[2:0];
  endtask

  task automatic expect_rec(input string tag, input logic [15:0] rec);
    check({tag, "_hi_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_hi_data"},  16'(out_data),  16'(rec[15:8]));
    check({tag, "_hi_last"},  16'(out_last),  16'd0);
    tick();
    check({tag, "_lo_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_lo_data"},  16'(out_data),  16'(rec[7:0]));
    check({tag, "_lo_last"},  16'(out_last),  16'd1);
    tick();
  endtask

  function automatic logic [15:0] stream_rec(input int k);
    return 16'(k * 16'h0B0D + 16'h0102);
  endfunction

  initial begin
    logic [15:0] r;
    res_valid    = 1'b0;
    min_sae      = '0;
    motion_vec_x = '0;
    motion_vec_y = '0;
    out_ready    = 1'b0;

    // reset state
    do_reset();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_count", 16'(fifo_count), 16'd0);
    check("rst_ovf",   16'(overflow), 16'd0);
    check("rst_drop",  16'(drop_cnt), 16'd0);
    check("rst_data",  16'(out_data), 16'd0);
    check("rst_last",  16'(out_last), 16'd0);
    check("rst_state", 16'(dbg_state), 16'(ST_IDLE));

    // single record, latency 2 cycles
    out_ready    = 1'b1;
    res_valid    = 1'b1;
    min_sae      = 10'h2A5;
    motion_vec_y = 3'd5;
    motion_vec_x = 3'd2;
    tick();
    res_valid = 1'b0;
    check("single_n1_valid", 16'(out_valid), 16'd0);
    check("single_n1_count", 16'(fifo_count), 16'd1);
    tick();
    check("single_hi_valid", 16'(out_valid), 16'd1);
    check("single_hi_data",  16'(out_data), 16'h00A9);
    check("single_hi_last",  16'(out_last), 16'd0);
    tick();
    check("single_lo_valid", 16'(out_valid), 16'd1);
    check("single_lo_data",  16'(out_data), 16'h006A);
    check("single_lo_last",  16'(out_last), 16'd1);
    tick();
    check("single_end_valid", 16'(out_valid), 16'd0);
    check("single_end_count", 16'(fifo_count), 16'd0);

    // back-pressure held in SEND_HI
    out_ready = 1'b0;
    drive_rec(16'hA96A);
    tick();
    res_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data",  16'(out_data), 16'h00A9);
      check("bp_hold_valid", 16'(out_valid), 16'd1);
      check("bp_hold_count", 16'(fifo_count), 16'd1);
      tick();
    end
    out_ready = 1'b1;
    expect_rec("bp", 16'hA96A);
    check("bp_end_valid", 16'(out_valid), 16'd0);

    // overflow: five pulses into depth 4 with the sink stalled
    out_ready = 1'b0;
    drive_rec(16'h1234); tick();
    drive_rec(16'h5678); tick();
    drive_rec(16'h9ABC); tick();
    drive_rec(16'hDEF0); tick();
    drive_rec(16'h0F0F); tick();
    res_valid = 1'b0;
    check("ovf_count", 16'(fifo_count), 16'd4);
    check("ovf_flag",  16'(overflow), 16'd1);
    check("ovf_drop",  16'(drop_cnt), 16'd1);
    check("ovf_state", 16'(dbg_state), 16'(ST_SEND_HI));
    out_ready = 1'b1;
    expect_rec("ovf_r1", 16'h1234);
    expect_rec("ovf_r2", 16'h5678);
    expect_rec("ovf_r3", 16'h9ABC);
    expect_rec("ovf_r4", 16'hDEF0);
    check("ovf_end_valid", 16'(out_valid), 16'd0);
    check("ovf_end_count", 16'(fifo_count), 16'd0);
    check("ovf_sticky",    16'(overflow), 16'd1);
    check("ovf_drop_keep", 16'(drop_cnt), 16'd1);

    // full FIFO, push coincides with SEND_LO handshake
    out_ready = 1'b0;
    do_reset();
    drive_rec(16'h1111); tick();
    drive_rec(16'h2222); tick();
    drive_rec(16'h3333); tick();
    drive_rec(16'h4444); tick();
    res_valid = 1'b0;
    check("sim_full_count", 16'(fifo_count), 16'd4);
    out_ready = 1'b1;
    check("sim_hi_data", 16'(out_data), 16'h0011);
    tick();
    check("sim_lo_data",  16'(out_data), 16'h0011);
    check("sim_lo_last",  16'(out_last), 16'd1);
    check("sim_lo_count", 16'(fifo_count), 16'd4);
    drive_rec(16'h5555);
    tick();
    res_valid = 1'b0;
    check("sim_after_count", 16'(fifo_count), 16'd4);
    check("sim_after_ovf",   16'(overflow), 16'd0);
    check("sim_after_drop",  16'(drop_cnt), 16'd0);
    expect_rec("sim_b", 16'h2222);
    expect_rec("sim_c", 16'h3333);
    expect_rec("sim_d", 16'h4444);
    expect_rec("sim_e", 16'h5555);
    check("sim_end_valid", 16'(out_valid), 16'd0);
    check("sim_end_count", 16'(fifo_count), 16'd0);

    // streaming 20 records, one every 2 cycles, across pointer wrap
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 42; c++) begin
      if ((c % 2 == 0) && (c < 40)) drive_rec(stream_rec(c / 2));
      else res_valid = 1'b0;
      if (c >= 2) begin
        r = stream_rec((c - 2) / 2);
        check("stream_valid", 16'(out_valid), 16'd1);
        check("stream_data",  16'(out_data), (c % 2 == 0) ? 16'(r[15:8]) : 16'(r[7:0]));
        check("stream_last",  16'(out_last), 16'(c % 2));
      end
      tick();
    end
    res_valid = 1'b0;
    check("stream_end_valid", 16'(out_valid), 16'd0);
    check("stream_end_count", 16'(fifo_count), 16'd0);
    check("stream_end_drop",  16'(drop_cnt), 16'd0);
    check("stream_end_ovf",   16'(overflow), 16'd0);

    // reset during SEND_LO with 3 queued, with a simultaneous res_valid
    out_ready = 1'b0;
    drive_rec(16'h0A0B); tick();
    drive_rec(16'h0C0D); tick();
    drive_rec(16'h0E0F); tick();
    res_valid = 1'b0;
    check("rstmid_state_hi", 16'(dbg_state), 16'(ST_SEND_HI));
    out_ready = 1'b1;
    tick();
    check("rstmid_state_lo", 16'(dbg_state), 16'(ST_SEND_LO));
    check("rstmid_lo_data",  16'(out_data), 16'h000B);
    check("rstmid_count",    16'(fifo_count), 16'd3);
    wb_rst_i  = 1'b1;
    out_ready = 1'b0;
    drive_rec(16'h7777);
    tick();
    wb_rst_i  = 1'b0;
    res_valid = 1'b0;
    check("rstmid_valid", 16'(out_valid), 16'd0);
    check("rstmid_cnt0",  16'(fifo_count), 16'd0);
    check("rstmid_data0", 16'(out_data), 16'd0);
    check("rstmid_last0", 16'(out_last), 16'd0);
    tick();
    check("rstmid_idle_valid", 16'(out_valid), 16'd0);
    check("rstmid_idle_count", 16'(fifo_count), 16'd0);
    out_ready = 1'b1;
    drive_rec(16'hA96A);
    tick();
    res_valid = 1'b0;
    check("fresh_n1_valid", 16'(out_valid), 16'd0);
    tick();
    expect_rec("fresh", 16'hA96A);
    check("fresh_end_valid", 16'(out_valid), 16'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
